// File: rtl/axi_pkg.sv
// axi_pkg: shared defaults, width helpers and ordering-mode encodings
package axi_pkg;
   localparam int ID_WIDTH_DEF  = 4;
   localparam int OST_DEPTH_DEF = 16;
   localparam int ORD_PER_ID    = 0;
   localparam int ORD_GLOBAL    = 1;
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/axi_idorder_list.sv
// axi_idorder_list: head/tail/count of one linked list threaded through the shared next[] array
module axi_idorder_list #(
   parameter int PTR_W = 4,
   parameter int CNT_W = 5
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [PTR_W-1:0] push_ptr,
   input  logic [PTR_W-1:0] next_ptr,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [CNT_W-1:0] cnt
);
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      head_d = pop ? next_ptr : head_q;
      // an empty list, or one being drained by a same-cycle pop, starts at the new slot
      if (push && (cnt_q == '0 || (pop && cnt_q == CNT_W'(1)))) head_d = push_ptr;
      tail_d = push ? push_ptr : tail_q;
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end
   assign head = head_q;
   assign tail = tail_q;
   assign cnt  = cnt_q;
endmodule

// File: rtl/axi_idorder_ll.sv
// axi_idorder_ll: linked-list AXI ID ordering tracker returning the next OST slot to retire per ID
module axi_idorder_ll
   import axi_pkg::*;
#(
   parameter int OST_DEPTH  = OST_DEPTH_DEF,
   parameter int ID_WIDTH   = ID_WIDTH_DEF,
   parameter int MAX_PER_ID = 16,
   parameter int ORDER_MODE = ORD_PER_ID,
   localparam int PTR_WIDTH = ptr_w(OST_DEPTH),
   localparam int TOT_WIDTH = cnt_w(OST_DEPTH),
   localparam int CNT_WIDTH = cnt_w(MAX_PER_ID),
   localparam int ID_NUM    = 2 ** ID_WIDTH
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   input  logic                 req_ready,
   input  logic [ID_WIDTH-1:0]  req_id,
   input  logic [PTR_WIDTH-1:0] req_ptr,
   output logic                 req_allow,
   input  logic                 resp_valid,
   input  logic                 resp_ready,
   input  logic [ID_WIDTH-1:0]  resp_id,
   input  logic                 resp_last,
   output logic                 resp_hit,
   output logic [PTR_WIDTH-1:0] resp_ptr,
   output logic [OST_DEPTH-1:0] resp_bits,
   output logic [TOT_WIDTH-1:0] ost_cnt,
   input  logic                 err_clr,
   output logic                 err_ovf,
   output logic                 err_order
);
   localparam logic [TOT_WIDTH-1:0] TOT_MAX = TOT_WIDTH'(OST_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PER_ID);
   logic [PTR_WIDTH-1:0] next_q [OST_DEPTH];
   logic [PTR_WIDTH-1:0] next_d [OST_DEPTH];
   logic [ID_WIDTH-1:0]  id_of_q [OST_DEPTH];
   logic [ID_WIDTH-1:0]  id_of_d [OST_DEPTH];
   logic [CNT_WIDTH-1:0] id_cnt [ID_NUM];
   logic [TOT_WIDTH-1:0] total;
   logic [PTR_WIDTH-1:0] head_sel, tail_sel;
   logic [OST_DEPTH-1:0] bits;
   logic hit, req_empty, hs_req, hs_last, push, pop;
   logic err_ovf_q, err_ovf_d, err_order_q, err_order_d;
   assign req_allow = (total < TOT_MAX) && (id_cnt[req_id] < CNT_MAX);
   assign hs_req    = req_valid && req_ready;
   assign hs_last   = resp_valid && resp_ready && resp_last;
   assign push      = hs_req && req_allow;
   assign pop       = hs_last && hit;
   generate
      if (ORDER_MODE == ORD_GLOBAL) begin : g_glob
         logic [PTR_WIDTH-1:0] gh, gt;
         logic [CNT_WIDTH-1:0] id_cnt_q [ID_NUM];
         logic [CNT_WIDTH-1:0] id_cnt_d [ID_NUM];
         axi_idorder_list #(.PTR_W(PTR_WIDTH), .CNT_W(TOT_WIDTH)) u_list (
            .clk, .rst_n, .push, .pop, .push_ptr(req_ptr), .next_ptr(next_q[gh]),
            .head(gh), .tail(gt), .cnt(total)
         );
         // per-ID counts only feed the admission limit in this mode
         always_comb begin
            id_cnt_d = id_cnt_q;
            if (push) id_cnt_d[req_id] = id_cnt_d[req_id] + CNT_WIDTH'(1);
            if (pop) id_cnt_d[resp_id] = id_cnt_d[resp_id] - CNT_WIDTH'(1);
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) id_cnt_q <= '{default: '0};
            else id_cnt_q <= id_cnt_d;
         end
         assign id_cnt    = id_cnt_q;
         assign hit       = (total != '0) && (id_of_q[gh] == resp_id);
         assign head_sel  = gh;
         assign tail_sel  = gt;
         assign req_empty = (total == '0);
         assign bits      = (total != '0) ? (OST_DEPTH'(1) << gh) : '0;
      end else begin : g_per_id
         logic [PTR_WIDTH-1:0] heads [ID_NUM];
         logic [PTR_WIDTH-1:0] tails [ID_NUM];
         logic [ID_NUM-1:0]    push_vec, pop_vec;
         logic [TOT_WIDTH-1:0] total_q, total_d;
         assign push_vec = push ? (ID_NUM'(1) << req_id) : '0;
         assign pop_vec  = pop ? (ID_NUM'(1) << resp_id) : '0;
         for (genvar i = 0; i < ID_NUM; i++) begin : g_list
            axi_idorder_list #(.PTR_W(PTR_WIDTH), .CNT_W(CNT_WIDTH)) u_list (
               .clk, .rst_n, .push(push_vec[i]), .pop(pop_vec[i]), .push_ptr(req_ptr),
               .next_ptr(next_q[heads[i]]), .head(heads[i]), .tail(tails[i]), .cnt(id_cnt[i])
            );
         end
         always_comb total_d = total_q + TOT_WIDTH'(push) - TOT_WIDTH'(pop);
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) total_q <= '0;
            else total_q <= total_d;
         end
         assign total     = total_q;
         assign hit       = (id_cnt[resp_id] != '0);
         assign head_sel  = heads[resp_id];
         assign tail_sel  = tails[req_id];
         assign req_empty = (id_cnt[req_id] == '0);
         always_comb begin
            bits = '0;
            for (int i = 0; i < ID_NUM; i++) if (id_cnt[i] != '0) bits[heads[i]] = 1'b1;
         end
      end
   endgenerate
   always_comb begin
      next_d  = next_q;
      id_of_d = id_of_q;
      if (push && !req_empty) next_d[tail_sel] = req_ptr;
      if (push) id_of_d[req_ptr] = req_id;
      err_ovf_d   = (hs_req && !req_allow) || (err_ovf_q && !err_clr);
      err_order_d = (hs_last && !hit) || (err_order_q && !err_clr);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_q      <= '{default: '0};
         id_of_q     <= '{default: '0};
         err_ovf_q   <= 1'b0;
         err_order_q <= 1'b0;
      end else begin
         next_q      <= next_d;
         id_of_q     <= id_of_d;
         err_ovf_q   <= err_ovf_d;
         err_order_q <= err_order_d;
      end
   end
   assign resp_hit  = hit;
   assign resp_ptr  = hit ? head_sel : '0;
   assign resp_bits = bits;
   assign ost_cnt   = total;
   assign err_ovf   = err_ovf_q;
   assign err_order = err_order_q;
endmodule

// File: doc/axi_idorder_ll.md
Name: axi_idorder_ll

Overview:
- Linked-list successor to the per-ID FIFO ordering tracker. Records the outstanding-table (OST) slot of each accepted AXI request and returns, per response ID, the slot that must retire next.
- Storage is one shared next-pointer array keyed by OST slot, instead of one full-depth FIFO per ID. Area scales with OST_DEPTH, not ID_NUM*OST_DEPTH.
- Adds a global in-order mode, a per-ID outstanding limit with admission output, and sticky protocol-error flags.
- Sits between the AXI master request path and its OST/response router.

Parameters:
- OST_DEPTH, 16, number of OST slots; slot index range 0..OST_DEPTH-1.
- ID_WIDTH, 4, AXI ID width; ID_NUM = 2**ID_WIDTH.
- MAX_PER_ID, 16, maximum outstanding transactions per ID (1..OST_DEPTH).
- ORDER_MODE, 0, 0 = in order per ID; 1 = strict global order across all IDs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid (snooped).
- req_ready  in  1  request ready (snooped).
- req_id  in  ID_WIDTH  request ID.
- req_ptr  in  PTR_WIDTH=$clog2(OST_DEPTH)  OST slot allocated to this request.
- req_allow  out  1  admission: tracker can accept an entry for req_id.
- resp_valid  in  1  response valid.
- resp_ready  in  1  response ready.
- resp_id  in  ID_WIDTH  response ID.
- resp_last  in  1  last beat; retires an entry.
- resp_hit  out  1  resp_id has a retirable head entry.
- resp_ptr  out  PTR_WIDTH  OST slot at the head for resp_id; 0 when resp_hit=0.
- resp_bits  out  OST_DEPTH  one-hot OR of all currently retirable head slots.
- ost_cnt  out  $clog2(OST_DEPTH+1)  total outstanding entries.
- err_clr  in  1  synchronous clear of the error flags.
- err_ovf  out  1  sticky: handshake accepted while req_allow=0 (entry dropped).
- err_order  out  1  sticky: resp_last handshake with resp_hit=0 (pop ignored).

Behaviour:
- State registers:
  - next[OST_DEPTH], id_of[OST_DEPTH].
  - Per list L: head[L], tail[L], cnt[L] (width $clog2(MAX_PER_ID+1)).
  - Global: total count, gh/gt head/tail.
- Mode 0: one list per ID. Mode 1: a single global list; the per-ID cnt array is kept only for the limit check.
- Reset (async, rst_n=0): all counts 0, all pointers 0, errors 0. Outputs: req_allow=1, resp_hit=0, resp_ptr=0, resp_bits=0, ost_cnt=0. A reset mid-operation discards every entry.
- Push: req_valid&&req_ready&&req_allow at the rising edge.
  - id_of[req_ptr]<=req_id.
  - If the list is empty: head<=req_ptr. Otherwise: next[tail]<=req_ptr.
  - tail<=req_ptr; cnt[req_id]++; total++.
- req_allow is combinational from registered state: (total<OST_DEPTH) && (cnt[req_id]<MAX_PER_ID). It does not depend on req_valid.
- resp_hit is combinational from registered state:
  - Mode 0: cnt[resp_id]!=0.
  - Mode 1: total!=0 && id_of[gh]==resp_id.
- resp_ptr = head of the selected list, zero-masked when resp_hit=0.
- Pop: resp_valid&&resp_ready&&resp_last&&resp_hit. Effect: head<=next[head]; cnt[resp_id]--; total--.
- Non-last beats never modify state.
- Simultaneous push and pop:
  - Both are evaluated against pre-edge state.
  - Same list with count 1: head<=req_ptr, tail<=req_ptr, count stays 1.
  - Same list with count 0: the push happens and the pop is an error. No bypass; a response cannot retire a request accepted in the same cycle.
  - Different lists: the updates are independent; total is unchanged.
- At total==OST_DEPTH, a pop and a push in the same cycle do not admit the push, because req_allow is computed from pre-edge state.
- Errors:
  - err_ovf sets on a handshake with req_allow=0; state is unchanged.
  - err_order sets on a last-beat handshake with resp_hit=0.
  - Both hold until err_clr=1. If a set and err_clr occur in the same cycle, set wins.
- Slot reuse: req_ptr must not currently be outstanding. This is the OST allocator's contract. The tracker does not check it; the assertion bench checks it.
- Latency: 0-cycle lookup; state updates 1 cycle after the handshake.
- resp_bits:
  - Mode 0: OR over IDs with cnt!=0 of (1<<head[id]).
  - Mode 1: (1<<gh) when total!=0.

Decomposition:
- Shared package axi_pkg: ID_WIDTH/OST_DEPTH defaults, the PTR_WIDTH/CNT_WIDTH $clog2 helper constants, and the ORDER_MODE encodings ORD_PER_ID=0 and ORD_GLOBAL=1.
- One natural sub-module: axi_idorder_list. It owns head/tail/cnt for a single list and receives push/pop strobes, with next[] read and write through ports. It is instantiated ID_NUM times in mode 0 and once in mode 1. The next[] and id_of[] arrays stay in the top level.

Test Plan (OST_DEPTH=8, ID_WIDTH=2, MAX_PER_ID=8 unless stated):
- Push (id1,ptr3), (id1,ptr5), (id2,ptr0) -> resp_id=1 gives resp_hit=1, resp_ptr=3; resp_bits=8'b0000_1001; ost_cnt=3. Last beat on id1 -> resp_ptr=5 next cycle.
- Non-last beat on id2, then last beat -> only the last beat retires ptr0; cnt[id2] goes 1->1->0; resp_hit for id2 drops to 0.
- Eight pushes -> req_allow=0, ost_cnt=8. Ninth handshake (id0,ptr7) -> err_ovf=1, ost_cnt stays 8. err_clr -> err_ovf=0.
- cnt[id3]=1 at ptr4; same cycle push (id3,ptr6) and pop id3 -> next cycle resp_ptr=6, cnt[id3]=1, ost_cnt unchanged.
- MAX_PER_ID=2: two pushes on id0 -> req_allow=0 for req_id=0 and 1 for req_id=1. Last beat on an empty id2 -> err_order=1, no state change.
- ORDER_MODE=1: push (id1,ptr2) then (id0,ptr6). resp_id=0 -> resp_hit=0. resp_id=1 -> resp_hit=1, resp_ptr=2. After that pop, resp_id=0 hits ptr6. Assert rst_n low mid-stream -> ost_cnt=0, resp_bits=0 immediately.
